// File: rtl/apb_slave_regbank.sv
// APB register-bank slave: DEPTH-word flop array behind one Pselx bit, with APB phase checking
// and saturating transfer counters. Define APB_SLV_ERRCNT_EN to add err_cnt and a status register.
module apb_slave_regbank #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SLAVES  = 4,
    parameter int unsigned SLV_IDX = 0,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic [SLAVES-1:0] Pselx,
    input  logic              Penable,
    input  logic              Pwrite,
    input  logic [WIDTH-1:0]  Paddr,
    input  logic [WIDTH-1:0]  Pwdata,
    output logic [WIDTH-1:0]  Prdata,
    output logic              prot_err,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
`ifdef APB_SLV_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned IW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IW-1:0]    r_idx;
    logic             r_wr;
    logic [WIDTH-1:0] r_prdata;
    logic             r_prot_err;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_sel;
    logic [IW-1:0]    w_idx;
    logic             w_match;
    logic             w_capture;
    logic             w_commit;
    logic             w_err;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_rd_val;
    logic             w_unused;

    assign w_sel    = Pselx[SLV_IDX];
    assign w_idx    = Paddr[IW+1:2];
    assign w_match  = (w_idx == r_idx) && (Pwrite == r_wr);
    assign w_unused = &{1'b0, Pselx, Paddr[WIDTH-1:IW+2], Paddr[1:0]};

    // State register
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phase tracking: next state plus capture/commit/error strobes
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel && !Penable) begin
                    w_state_nxt = ST_SETUP;
                    w_capture   = 1'b1;
                end else if (w_sel) begin
                    w_err = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!w_sel) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!Penable) begin
                    w_err     = 1'b1;
                    w_capture = 1'b1;
                end else if (w_match) begin
                    w_state_nxt = ST_ACCESS;
                    w_commit    = 1'b1;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!w_sel) begin
                    w_state_nxt = ST_IDLE;
                end else if (!Penable) begin
                    w_state_nxt = ST_SETUP;
                    w_capture   = 1'b1;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef APB_SLV_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Top index is a read-only status word
    always_comb begin
        w_wr_ok  = (r_idx != IW'(DEPTH - 1));
        w_rd_val = r_mem[w_idx];
        if (w_idx == IW'(DEPTH - 1)) begin
            w_rd_val = WIDTH'({r_err_cnt, 8'(r_rd_cnt), 8'(r_wr_cnt)});
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign w_wr_ok  = 1'b1;
    assign w_rd_val = r_mem[w_idx];
`endif

    // Register array, read-data capture and saturating counters
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_idx      <= '0;
            r_wr       <= 1'b0;
            r_prdata   <= '0;
            r_prot_err <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_prot_err <= w_err;
            if (w_capture) begin
                r_idx <= w_idx;
                r_wr  <= Pwrite;
                if (!Pwrite) begin
                    r_prdata <= w_rd_val;
                end
            end
            if (w_commit) begin
                if (r_wr) begin
                    if (w_wr_ok) begin
                        r_mem[r_idx] <= Pwdata;
                    end
                    if (r_wr_cnt != '1) begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                    end
                end else if (r_rd_cnt != '1) begin
                    r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign Prdata   = r_prdata;
    assign prot_err = r_prot_err;
    assign wr_cnt   = r_wr_cnt;
    assign rd_cnt   = r_rd_cnt;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank: transaction-level reference model pushes per-cycle
// expectations, a negedge monitor pops and compares. Narrow counters exercise saturation.
module tb_apb_slave_regbank;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SLAVES  = 4;
    localparam int unsigned SLV_IDX = 0;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IW      = $clog2(DEPTH);
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic              Hclk = 1'b0;
    logic              Hreset;
    logic [SLAVES-1:0] Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [WIDTH-1:0]  Paddr;
    logic [WIDTH-1:0]  Pwdata;
    logic [WIDTH-1:0]  Prdata;
    logic              prot_err;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
`ifdef APB_SLV_ERRCNT_EN
    logic [7:0]        err_cnt;
`endif

    apb_slave_regbank #(
        .WIDTH(WIDTH), .SLAVES(SLAVES), .SLV_IDX(SLV_IDX), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .prot_err(prot_err),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
`ifdef APB_SLV_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        logic             err;
        logic [WIDTH-1:0] prdata;
        int               wr;
        int               rd;
        int               ec;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] m_prdata;
    int               m_wr, m_rd, m_ec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] m_read(input int idx);
`ifdef APB_SLV_ERRCNT_EN
        if (idx == DEPTH - 1) return WIDTH'({8'(m_ec), 8'(m_rd), 8'(m_wr)});
`endif
        return m_mem[idx];
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_prdata = '0;
        m_wr = 0;
        m_rd = 0;
        m_ec = 0;
    endtask

    task automatic m_setup(input logic wr, input int idx);
        if (!wr) m_prdata = m_read(idx);
    endtask

    task automatic m_commit(input logic wr, input int idx, input logic [WIDTH-1:0] d);
        if (wr) begin
            m_wr = sat(m_wr, CMAX);
`ifdef APB_SLV_ERRCNT_EN
            if (idx != DEPTH - 1) m_mem[idx] = d;
`else
            m_mem[idx] = d;
`endif
        end else begin
            m_rd = sat(m_rd, CMAX);
        end
    endtask

    task automatic m_error();
        m_ec = sat(m_ec, 255);
    endtask

    task automatic push(input logic err);
        exp_q.push_back('{err, m_prdata, m_wr, m_rd, m_ec});
    endtask

    function automatic logic [SLAVES-1:0] vec(input logic s);
        logic [SLAVES-1:0] v;
        v = SLAVES'($urandom);
        v[SLV_IDX] = s;
        return v;
    endfunction

    // One bus cycle: drive at negedge, return just after the sampling edge
    task automatic cyc(input logic [SLAVES-1:0] v, input logic en, input logic wr, input int idx,
                       input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] a;
        @(negedge Hclk);
        a = $urandom;
        a[IW+1:2] = IW'(idx);
        Pselx = v; Penable = en; Pwrite = wr; Paddr = a; Pwdata = d;
        @(posedge Hclk);
    endtask

    task automatic idle();
        cyc(vec(1'b0), 1'($urandom), 1'($urandom), 0, $urandom);
        push(1'b0);
    endtask

    task automatic good(input logic wr, input int idx, input logic [WIDTH-1:0] d);
        cyc(vec(1'b1), 1'b0, wr, idx, $urandom);
        m_setup(wr, idx);
        push(1'b0);
        cyc(vec(1'b1), 1'b1, wr, idx, d);
        m_commit(wr, idx, d);
        push(1'b0);
    endtask

    task automatic err_enable_from_idle();
        idle();
        cyc(vec(1'b1), 1'b1, 1'($urandom), $urandom_range(0, DEPTH - 1), $urandom);
        m_error();
        push(1'b1);
    endtask

    task automatic err_changed(input logic wr, input int idx, input logic wr2, input int idx2);
        cyc(vec(1'b1), 1'b0, wr, idx, $urandom);
        m_setup(wr, idx);
        push(1'b0);
        cyc(vec(1'b1), 1'b1, wr2, idx2, $urandom);
        m_error();
        push(1'b1);
    endtask

    task automatic err_long_enable(input logic wr, input int idx);
        good(wr, idx, $urandom);
        cyc(vec(1'b1), 1'b1, wr, idx, $urandom);
        m_error();
        push(1'b1);
    endtask

    task automatic err_resetup(input logic wr, input int idx, input logic wr2, input int idx2);
        logic [WIDTH-1:0] d;
        d = $urandom;
        cyc(vec(1'b1), 1'b0, wr, idx, $urandom);
        m_setup(wr, idx);
        push(1'b0);
        cyc(vec(1'b1), 1'b0, wr2, idx2, $urandom);
        m_setup(wr2, idx2);
        m_error();
        push(1'b1);
        cyc(vec(1'b1), 1'b1, wr2, idx2, d);
        m_commit(wr2, idx2, d);
        push(1'b0);
    endtask

    task automatic err_drop_sel(input logic wr, input int idx);
        cyc(vec(1'b1), 1'b0, wr, idx, $urandom);
        m_setup(wr, idx);
        push(1'b0);
        cyc(vec(1'b0), 1'($urandom), wr, idx, $urandom);
        m_error();
        push(1'b1);
    endtask

    task automatic deselected_write(input logic [SLAVES-1:0] v, input int idx);
        cyc(v, 1'b0, 1'b1, idx, $urandom);
        push(1'b0);
        cyc(v, 1'b1, 1'b1, idx, $urandom);
        push(1'b0);
    endtask

    task automatic release_reset();
        @(negedge Hclk);
        Pselx = '0; Penable = 1'b0;
        Hreset = 1'b0;
        @(posedge Hclk);
        push(1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_prdata"}, Prdata, '0);
        chk({tag, "_prot_err"}, 32'(prot_err), 32'd0);
        chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
        chk({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd0);
    endtask

    // Monitor: one expectation per sampled edge, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge Hclk);
            if (!Hreset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("prot_err", 32'(prot_err), 32'(e.err));
                chk("prdata", Prdata, e.prdata);
                chk("wr_cnt", 32'(wr_cnt), 32'(e.wr));
                chk("rd_cnt", 32'(rd_cnt), 32'(e.rd));
`ifdef APB_SLV_ERRCNT_EN
                chk("err_cnt", 32'(err_cnt), 32'(e.ec));
`endif
            end
        end
    end

    initial begin
        int kind, idx, idx2;
        logic wr, wr2;
        Hreset = 1'b1;
        Pselx = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
        m_reset();
        #12;
        check_zero("reset");
        release_reset();

        // Select isolation straight out of reset
        deselected_write(4'b0010, 3);
        idle();

        // Write then read back
        good(1'b1, 2, 32'hDEADBEEF);
        idle();
        good(1'b0, 2, $urandom);
        idle();

        // Back-to-back writes then reads
        good(1'b1, 0, 32'h1111_0000);
        good(1'b1, 1, 32'h2222_0004);
        good(1'b1, 2, 32'h3333_0008);
        good(1'b0, 0, $urandom);
        good(1'b0, 1, $urandom);
        good(1'b0, 2, $urandom);
        idle();

        // Protocol errors
        err_enable_from_idle();
        good(1'b1, 3, 32'hC0C0_000C);
        err_changed(1'b1, 1, 1'b1, 3);
        good(1'b0, 1, $urandom);
        good(1'b0, 3, $urandom);
        err_long_enable(1'b1, 5);
        err_resetup(1'b0, 2, 1'b1, 6);
        err_drop_sel(1'b0, 3);
        idle();

        // Asynchronous reset in the SETUP cycle of a write to 0x10
        cyc(vec(1'b1), 1'b0, 1'b1, 4, $urandom);
        m_setup(1'b1, 4);
        push(1'b0);
        @(negedge Hclk);
        #2;
        Hreset = 1'b1; Penable = 1'b1; Pwdata = 32'h1234_5678;
        #1;
        check_zero("async_reset");
        m_reset();
        @(posedge Hclk);
        #1;
        check_zero("held_reset");
        release_reset();
        good(1'b0, 4, $urandom);
        idle();

        // Saturation of the narrow write counter
        for (int i = 0; i < 20; i++) good(1'b1, i % DEPTH, $urandom);
        idle();

        // Randomized mix
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, DEPTH - 1);
            wr   = 1'($urandom);
            case ($urandom_range(0, 2))
                0: begin idx2 = (idx + $urandom_range(1, DEPTH - 1)) % DEPTH; wr2 = wr; end
                1: begin idx2 = idx; wr2 = ~wr; end
                default: begin idx2 = (idx + $urandom_range(1, DEPTH - 1)) % DEPTH; wr2 = ~wr; end
            endcase
            case (kind)
                0, 1, 2: good(wr, idx, $urandom);
                3: err_enable_from_idle();
                4: err_changed(wr, idx, wr2, idx2);
                5: err_long_enable(wr, idx);
                6: err_resetup(wr, idx, 1'($urandom), idx2);
                7: err_drop_sel(wr, idx);
                8: idle();
                default: deselected_write(vec(1'b0), idx);
            endcase
        end

`ifdef APB_SLV_ERRCNT_EN
        good(1'b1, DEPTH - 1, 32'hFFFF_FFFF);
        good(1'b0, DEPTH - 1, $urandom);
`endif
        idle();
        @(negedge Hclk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
APB peripheral that sits directly downstream of the AHB-to-APB bridge. It responds to one bit of the bridge's one-hot Pselx bus and serves as a DEPTH-word register bank. It runs an APB phase-tracking FSM that flags protocol violations by the bridge, and it counts completed transfers. It serves as the bridge's APB-side DUT partner in the bridge bench.

Parameters:
WIDTH, 32, data and address width; matches `WIDTH.
SLAVES, 4, width of Pselx; matches `SLAVES.
SLV_IDX, 0, the Pselx bit this instance responds to (0..SLAVES-1).
DEPTH, 16, number of WIDTH-bit registers; must be a power of 2, at least 2.
CNT_W, 16, width of the transfer counters.

Ports:
Hclk  in  1  clock; everything is sampled on the rising edge.
Hreset  in  1  asynchronous, active-high reset.
Pselx  in  SLAVES  one-hot select from the bridge; only bit SLV_IDX is used (sel).
Penable  in  1  APB access-phase strobe.
Pwrite  in  1  1 = write, 0 = read.
Paddr  in  WIDTH  byte address; word index = Paddr[IW+1:2], where IW = log2(DEPTH). Upper bits are ignored.
Pwdata  in  WIDTH  write data.
Prdata  out  WIDTH  read data.
prot_err  out  1  one-cycle pulse on a protocol violation.
wr_cnt  out  CNT_W  number of completed writes.
rd_cnt  out  CNT_W  number of completed reads.

Behaviour:
- Reset (async, Hreset=1):
  - FSM goes to IDLE.
  - Prdata, prot_err, wr_cnt and rd_cnt = 0.
  - All registers = 0.
  - Captured address and direction are cleared.
- FSM states are IDLE, SETUP and ACCESS. Transitions are evaluated on each rising edge from (sel, Penable).
- IDLE:
  - sel=1, Penable=0: go to SETUP; capture index and Pwrite.
  - sel=1, Penable=1: pulse prot_err; stay in IDLE.
  - sel=0: stay in IDLE.
- SETUP:
  - sel=1, Penable=1, Paddr index and Pwrite equal the captured values: go to ACCESS.
  - Same, but index or direction changed: pulse prot_err; go to IDLE; no access.
  - sel=1, Penable=0: pulse prot_err; treat as a fresh SETUP and recapture.
  - sel=0: pulse prot_err; go to IDLE.
- Write commit: on the edge SETUP->ACCESS with Pwrite=1, reg[index] <= Pwdata sampled at that edge; wr_cnt increments.
- Read data: on the edge IDLE/ACCESS->SETUP with Pwrite=0, Prdata <= reg[index]. Prdata is therefore stable throughout the ACCESS cycle, and rd_cnt increments on the SETUP->ACCESS edge.
  - Prdata holds its value at all other times; writes never change Prdata.
- ACCESS:
  - sel=1, Penable=0: back-to-back transfer; go to SETUP with recapture (read data is loaded as above).
  - sel=0: go to IDLE.
  - sel=1, Penable=1: Penable held longer than one cycle; pulse prot_err; go to IDLE; no second access.
- Counters saturate at all-ones and never wrap.
- prot_err is registered: it is high for exactly the one cycle after the offending edge.
- Pselx bits other than SLV_IDX are ignored entirely. Multiple bits set is not this block's check.
- A read immediately after a write to the same index returns the new data: the write commits at SETUP->ACCESS, before the next SETUP load.
- Reset asserted mid-transfer aborts the transfer. No write commits on the edge where Hreset=1.
- Implementation: flop array plus FSM, no inferred RAM. Expected size is 150-250 lines.

Optional Feature:
Macro APB_SLV_ERRCNT_EN.
- Defined:
  - Adds output err_cnt (8 bits, reset 0), which increments on each prot_err pulse and saturates at 255.
  - Adds the read-only register index DEPTH-1: a read of it returns {err_cnt, rd_cnt[7:0], wr_cnt[7:0]}, zero-extended to WIDTH.
  - Writes to index DEPTH-1 are dropped, but wr_cnt still counts them.
- Not defined: there is no err_cnt port, and index DEPTH-1 is an ordinary read/write register.

Test Plan:
1. Write and read back: write 0xDEADBEEF to Paddr 0x08, then read Paddr 0x08 -> Prdata = 0xDEADBEEF during the read ACCESS cycle; wr_cnt=1; rd_cnt=1; prot_err never asserted.
2. Back-to-back writes: writes to 0x00, 0x04 and 0x08 with no idle cycles (ACCESS->SETUP each time), followed by three reads -> data matches; wr_cnt=3; rd_cnt=3.
3. Protocol errors: (a) Penable=1 from IDLE; (b) Paddr changed from 0x04 to 0x0C between SETUP and ACCESS; (c) Penable held 2 cycles -> prot_err pulses 1 cycle each time; for (b), a subsequent read of 0x04 and 0x0C returns the previous contents.
4. Select isolation: SLV_IDX=0, drive a full write with Pselx=4'b0010 -> no register change, counters stay 0, no prot_err.
5. Reset mid-operation: assert Hreset asynchronously in the SETUP cycle of a write to 0x10 -> FSM is IDLE, outputs are 0, and a read of 0x10 after release returns 0.
6. Saturation: with CNT_W=4, perform 20 writes -> wr_cnt stays at 0xF. With APB_SLV_ERRCNT_EN defined, a read of index DEPTH-1 returns err_cnt in bits [23:16].
